// File: rtl/and16_qual_if.sv
// Bus between the AND16 qualifier and its consumer.
// master: drives SP (enable), Z0 (raw AND16 output) and CLR; observes the outputs.
// slave : the qualifier itself; returns Q, RISE, FALL, EVCNT and OVF.
interface and16_qual_if #(
  parameter int unsigned EVT_W = 8
);
  logic             SP;
  logic             Z0;
  logic             CLR;
  logic             Q;
  logic             RISE;
  logic             FALL;
  logic [EVT_W-1:0] EVCNT;
  logic             OVF;

  modport master (
    output SP, Z0, CLR,
    input  Q, RISE, FALL, EVCNT, OVF
  );

  modport slave (
    input  SP, Z0, CLR,
    output Q, RISE, FALL, EVCNT, OVF
  );
endinterface

// File: rtl/and16_qual.sv
// Qualifier for the AND16 all-ones detector output.
// Synchronises Z0, debounces it with separate assert/release dwell counts and produces a
// clean level Q, one-cycle RISE/FALL pulses and a saturating RISE event counter with a
// sticky overflow flag.
// Ports:
//   CK  - clock, rising edge
//   CD  - asynchronous active-high reset
//   bus - slave side of and16_qual_if (SP, Z0, CLR in; Q, RISE, FALL, EVCNT, OVF out)
module and16_qual #(
  parameter int unsigned ON_CNT  = 4,
  parameter int unsigned OFF_CNT = 2,
  parameter int unsigned EVT_W   = 8
) (
  input  logic         CK,
  input  logic         CD,
  and16_qual_if.slave  bus
);

  localparam int unsigned MaxCnt = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
  localparam logic [CntW-1:0] OnLast  = CntW'(ON_CNT - 1);
  localparam logic [CntW-1:0] OffLast = CntW'(OFF_CNT - 1);

  typedef enum logic [1:0] {StIdle, StArm, StActive, StRel} state_e;

  logic             s1_q, zs_q;
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [EVT_W-1:0] evcnt_q, evcnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    evcnt_d = evcnt_q;
    ovf_d   = ovf_q;

    if (bus.SP) begin
      case (state_q)
        StIdle: begin
          if (zs_q) begin
            if (ON_CNT == 1) begin
              state_d = StActive;
              q_d     = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StArm;
              cnt_d   = CntW'(1);
            end
          end
        end
        StArm: begin
          if (!zs_q) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == OnLast) begin
            state_d = StActive;
            q_d     = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StActive: begin
          if (!zs_q) begin
            if (OFF_CNT == 1) begin
              state_d = StIdle;
              q_d     = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StRel;
              cnt_d   = CntW'(1);
            end
          end
        end
        StRel: begin
          if (zs_q) begin
            state_d = StActive;
            cnt_d   = '0;
          end else if (cnt_q == OffLast) begin
            state_d = StIdle;
            q_d     = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          q_d     = 1'b0;
          cnt_d   = '0;
        end
      endcase

      // CLR wins over counting, but a RISE on the same edge still counts as one event.
      if (bus.CLR) begin
        evcnt_d = rise_d ? EVT_W'(1) : '0;
        ovf_d   = 1'b0;
      end else if (rise_d) begin
        if (&evcnt_q) ovf_d = 1'b1;
        else          evcnt_d = evcnt_q + EVT_W'(1);
      end
    end
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      s1_q    <= 1'b0;
      zs_q    <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evcnt_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // Synchroniser runs regardless of SP.
      s1_q    <= bus.Z0;
      zs_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evcnt_q <= evcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.RISE  = rise_q;
  assign bus.FALL  = fall_q;
  assign bus.EVCNT = evcnt_q;
  assign bus.OVF   = ovf_q;

endmodule
